// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush and a multi-cycle
// multiply/divide occupancy window, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [4:0]  EX_rt,
    input  logic        EX_MemRead,
    input  logic        branch_taken,
    input  logic        md_start,
    output logic        PC_enable,
    output logic        IF_ID_enable,
    output logic        ID_EX_enable,
    output logic        IF_ID_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {StRun, StMdBusy, StFlush} state_e;

    localparam logic [5:0] MdLoad = 6'(MD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_d;
    logic        load_use;

    assign load_use = EX_MemRead && (EX_rt != 5'd0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));

    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        PC_enable    = 1'b0;
        IF_ID_enable = 1'b0;
        ID_EX_enable = 1'b0;
        IF_ID_flush  = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (reset) begin
            // Pipeline is frozen while reset is held.
            PC_enable    = 1'b1;
            IF_ID_enable = 1'b1;
            ID_EX_enable = 1'b1;
        end else begin
            case (state_q)
                StRun: begin
                    if (branch_taken) begin
                        state_d = StFlush;
                    end else if (md_start) begin
                        state_d  = StMdBusy;
                        md_cnt_d = MdLoad;
                    end else if (load_use) begin
                        PC_enable    = 1'b1;
                        IF_ID_enable = 1'b1;
                        ID_EX_enable = 1'b1;
                    end
                end
                StFlush: begin
                    IF_ID_flush  = 1'b1;
                    ID_EX_enable = 1'b1;
                    state_d      = StRun;
                end
                StMdBusy: begin
                    PC_enable    = 1'b1;
                    IF_ID_enable = 1'b1;
                    ID_EX_enable = 1'b1;
                    md_busy      = 1'b1;
                    if (md_cnt_q == 6'd0) begin
                        md_done = 1'b1;
                        state_d = StRun;
                    end else begin
                        md_cnt_d = md_cnt_q - 6'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_cycles;
        if ((PC_enable || ID_EX_enable) && (stall_cycles != 16'hFFFF)) begin
            stall_d = stall_cycles + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            md_cnt_q     <= 6'd0;
            stall_cycles <= 16'd0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            stall_cycles <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        EX_MemRead, branch_taken, md_start;
    logic        PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush, md_busy, md_done;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.MD_CYCLES(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .EX_rt        (EX_rt),
        .EX_MemRead   (EX_MemRead),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .PC_enable    (PC_enable),
        .IF_ID_enable (IF_ID_enable),
        .ID_EX_enable (ID_EX_enable),
        .IF_ID_flush  (IF_ID_flush),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
        EX_MemRead = 1'b0; branch_taken = 1'b0; md_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk); #1;
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush, md_busy, md_done} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 111000",
                     {PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush, md_busy, md_done});
        end
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d required 0", stall_cycles);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_enables: got %b required 0000",
                     {PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush});
        end
        @(negedge clk); #1;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL idle_stall: got %0d required 0", stall_cycles);
        end
    endtask

    task automatic test_load_use();
        logic [15:0] s0;
        s0 = stall_cycles;
        EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_rt = 5'd9;
        #1;
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush} !== 4'b1110) begin
            errors++;
            $display("FAIL load_use_rs: got %b required 1110",
                     {PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush});
        end
        @(negedge clk);
        EX_rt = 5'd7; ID_rs = 5'd1; ID_rt = 5'd7;
        #1;
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_rt: got %b required 111",
                     {PC_enable, IF_ID_enable, ID_EX_enable});
        end
        @(negedge clk);
        EX_MemRead = 1'b0;
        #1;
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable} !== 3'b000) begin
            errors++;
            $display("FAIL no_memread: got %b required 000", {PC_enable, IF_ID_enable, ID_EX_enable});
        end
        checks++;
        if (stall_cycles !== s0 + 16'd2) begin
            errors++;
            $display("FAIL load_use_count: got %0d required %0d", stall_cycles, s0 + 16'd2);
        end
        clear_inputs();
    endtask

    task automatic test_zero_reg();
        logic [15:0] s0;
        s0 = stall_cycles;
        EX_MemRead = 1'b1; EX_rt = 5'd0; ID_rt = 5'd0; ID_rs = 5'd0;
        #1;
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable} !== 3'b000) begin
            errors++;
            $display("FAIL zero_reg: got %b required 000", {PC_enable, IF_ID_enable, ID_EX_enable});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== s0) begin
            errors++;
            $display("FAIL zero_reg_count: got %0d required %0d", stall_cycles, s0);
        end
    endtask

    task automatic test_md();
        logic [15:0] s0;
        int busy_n = 0;
        int done_at = 0;
        int done_n = 0;
        int bad_en = 0;
        s0 = stall_cycles;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        // Hazards and a branch while busy must be ignored.
        EX_MemRead = 1'b1; EX_rt = 5'd3; ID_rs = 5'd3;
        for (int i = 0; i < 40; i++) begin
            if (i != 0) @(negedge clk);
            branch_taken = (i == 5);
            md_start = (i == 7);
            #1;
            if (!md_busy) break;
            busy_n++;
            if (md_done) begin
                done_at = busy_n;
                done_n++;
            end
            if (!(PC_enable && IF_ID_enable && ID_EX_enable) || IF_ID_flush) bad_en++;
        end
        checks++;
        if (busy_n != 32) begin
            errors++;
            $display("FAIL md_busy_len: got %0d required 32", busy_n);
        end
        checks++;
        if (done_at != 32 || done_n != 1) begin
            errors++;
            $display("FAIL md_done_pos: got cycle %0d count %0d required cycle 32 count 1",
                     done_at, done_n);
        end
        checks++;
        if (bad_en != 0) begin
            errors++;
            $display("FAIL md_enables: got %0d bad cycles required 0", bad_en);
        end
        checks++;
        if (stall_cycles !== s0 + 16'd32) begin
            errors++;
            $display("FAIL md_count: got %0d required %0d", stall_cycles, s0 + 16'd32);
        end
        // First RUN cycle after MD_BUSY sees the pending load-use.
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable, md_busy, md_done} !== 5'b11100) begin
            errors++;
            $display("FAIL md_after_hazard: got %b required 11100",
                     {PC_enable, IF_ID_enable, ID_EX_enable, md_busy, md_done});
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        logic [15:0] s0;
        branch_taken = 1'b1; md_start = 1'b1;
        EX_MemRead = 1'b1; EX_rt = 5'd4; ID_rt = 5'd4;
        @(negedge clk);
        branch_taken = 1'b0; md_start = 1'b1;
        s0 = stall_cycles;
        #1;
        checks++;
        if ({IF_ID_flush, ID_EX_enable, PC_enable, IF_ID_enable, md_busy} !== 5'b11000) begin
            errors++;
            $display("FAIL flush_cycle: got %b required 11000",
                     {IF_ID_flush, ID_EX_enable, PC_enable, IF_ID_enable, md_busy});
        end
        @(negedge clk);
        md_start = 1'b0;
        #1;
        checks++;
        if ({IF_ID_flush, md_busy, PC_enable, IF_ID_enable, ID_EX_enable} !== 5'b00111) begin
            errors++;
            $display("FAIL flush_after: got %b required 00111",
                     {IF_ID_flush, md_busy, PC_enable, IF_ID_enable, ID_EX_enable});
        end
        checks++;
        if (stall_cycles !== s0 + 16'd1) begin
            errors++;
            $display("FAIL flush_count: got %0d required %0d", stall_cycles, s0 + 16'd1);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_md: got %b required 0", md_busy);
        end
    endtask

    task automatic test_reset_mid_md();
        int stray = 0;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL md_cycle10_busy: got %b required 1", md_busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush, md_busy, md_done} !== 6'b111000
            || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL mid_md_reset: got %b stall %0d required 111000 stall 0",
                     {PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush, md_busy, md_done},
                     stall_cycles);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (md_busy || md_done || PC_enable || ID_EX_enable) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL post_reset_run: got %0d busy/stall cycles required 0", stray);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        EX_MemRead = 1'b1; EX_rt = 5'd12; ID_rs = 5'd12;
        repeat (65534) @(negedge clk);
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_before: got %h required fffe", stall_cycles);
        end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got %h required ffff", stall_cycles);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_md();
        test_branch_priority();
        test_reset_mid_md();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 32, multiply/divide occupancy in cycles; legal range 2..63.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 ID_rs  input  5  rs field of instruction in ID.
REQ-005 ID_rt  input  5  rt field of instruction in ID.
REQ-006 EX_rt  input  5  destination rt of instruction in EX.
REQ-007 EX_MemRead  input  1  instruction in EX is a load.
REQ-008 branch_taken  input  1  branch resolved taken this cycle.
REQ-009 md_start  input  1  instruction in ID is mult/div and requests the unit.
REQ-010 PC_enable  output  1  0 = PC loads, 1 = PC holds.
REQ-011 IF_ID_enable  output  1  0 = IF/ID loads, 1 = IF/ID holds.
REQ-012 ID_EX_enable  output  1  0 = ID/EX loads, 1 = ID/EX bubbles.
REQ-013 IF_ID_flush  output  1  1 = IF/ID contents discarded.
REQ-014 md_busy  output  1  multiply/divide unit occupied.
REQ-015 md_done  output  1  one-cycle pulse on last busy cycle.
REQ-016 stall_cycles  output  16  count of cycles with any hold/bubble asserted.

Function
REQ-017 The block SHALL implement states RUN, MD_BUSY, FLUSH, with a 6-bit down-counter md_cnt.
REQ-018 Load-use hazard SHALL be defined as EX_MemRead=1, EX_rt!=0, and (EX_rt==ID_rs or EX_rt==ID_rt).
REQ-019 In RUN with no event, all of PC_enable, IF_ID_enable, ID_EX_enable, IF_ID_flush SHALL be 0.
REQ-020 In RUN with load-use hazard (and no higher-priority event), PC_enable=1, IF_ID_enable=1, ID_EX_enable=1 combinationally in that same cycle; state remains RUN.
REQ-021 In RUN, branch_taken=1 SHALL move to FLUSH next edge; priority branch_taken > md_start > load-use.
REQ-022 In RUN, md_start=1 (no branch) SHALL move to MD_BUSY next edge and load md_cnt=MD_CYCLES-1.
REQ-023 In FLUSH (exactly one cycle): IF_ID_flush=1, ID_EX_enable=1, PC_enable=0, IF_ID_enable=0; md_start and load-use ignored; next state RUN.
REQ-024 In MD_BUSY: PC_enable=1, IF_ID_enable=1, ID_EX_enable=1, md_busy=1; md_cnt decrements each edge; branch_taken, md_start, load-use ignored.
REQ-025 MD_BUSY SHALL last exactly MD_CYCLES cycles; md_done=1 only in the cycle md_cnt==0, then state RUN.
REQ-026 Any hazard present in the first RUN cycle after MD_BUSY or FLUSH SHALL be evaluated normally.
REQ-027 stall_cycles SHALL increment on each edge where PC_enable=1 or ID_EX_enable=1, saturating at 16'hFFFF.
REQ-028 md_busy and md_done SHALL be 0 outside MD_BUSY.

Reset
REQ-029 While reset=1: state=RUN, md_cnt=0, stall_cycles=0, PC_enable=1, IF_ID_enable=1, ID_EX_enable=1, IF_ID_flush=0, md_busy=0, md_done=0.
REQ-030 Reset asserted mid-MD_BUSY or mid-FLUSH SHALL abort the operation with no md_done pulse; first cycle after release is RUN.

Verification
REQ-031 Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 for one cycle -> all three enables 1 that cycle, stall_cycles +1, state RUN.
REQ-032 Zero register: EX_MemRead=1, EX_rt=0, ID_rt=0 -> no stall, enables 0.
REQ-033 MD: md_start pulse, MD_CYCLES=32 -> md_busy high exactly 32 cycles, md_done on the 32nd, stall_cycles +32.
REQ-034 Simultaneous branch_taken=1, md_start=1, load-use -> FLUSH next cycle (IF_ID_flush=1 one cycle), no MD_BUSY entry.
REQ-035 Reset at cycle 10 of MD_BUSY -> outputs at reset values immediately, no md_done, RUN after release.
REQ-036 Saturation: hold load-use for 65540 cycles -> stall_cycles stops at 16'hFFFF.
